// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master data-memory arbiter with M1 starvation guard and lock
module dmem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_wdata_i,
    input  logic [3:0]    m0_wstrb_i,
    output logic          m0_gnt_o,
    output logic          m0_rvalid_o,
    output logic [DW-1:0] m0_rdata_o,
    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_wdata_i,
    input  logic [3:0]    m1_wstrb_i,
    input  logic          m1_lock_i,
    output logic          m1_gnt_o,
    output logic          m1_rvalid_o,
    output logic [DW-1:0] m1_rdata_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic [3:0]    mem_wstrb_o,
    input  logic [DW-1:0] mem_rdata_i
);

    localparam int SW = ($clog2(STARVE_MAX + 1) > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, LOCK1} state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_owner_q, rd_owner_d;   // 1 = read belongs to M1
    logic          m1_win;

    // Arbitration, next state, starvation counter and request mux
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        rd_valid_d  = 1'b0;
        rd_owner_d  = rd_owner_q;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wstrb_o = '0;

        // M1 wins when locked, starved, or uncontested; reset masks both grants
        m1_win   = m1_req_i && ((state_q == LOCK1) || (starve_q == SMAX) || !m0_req_i);
        m1_gnt_o = rst_n && m1_win;
        m0_gnt_o = rst_n && m0_req_i && !m1_win && (state_q != LOCK1);
        mem_en_o = m0_gnt_o | m1_gnt_o;

        if (m0_gnt_o) begin
            mem_we_o    = m0_we_i;
            mem_addr_o  = m0_addr_i;
            mem_wdata_o = m0_wdata_i;
            mem_wstrb_o = m0_wstrb_i;
            rd_valid_d  = !m0_we_i;
            rd_owner_d  = m0_we_i ? rd_owner_q : 1'b0;
        end else if (m1_gnt_o) begin
            mem_we_o    = m1_we_i;
            mem_addr_o  = m1_addr_i;
            mem_wdata_o = m1_wdata_i;
            mem_wstrb_o = m1_wstrb_i;
            rd_valid_d  = !m1_we_i;
            rd_owner_d  = m1_we_i ? rd_owner_q : 1'b1;
        end

        if (m0_gnt_o) begin
            state_d = OWN0;
        end else if (m1_gnt_o) begin
            state_d = m1_lock_i ? LOCK1 : OWN1;
        end else if (state_q == LOCK1) begin
            state_d = OWN1;
        end else begin
            state_d = IDLE;
        end

        if (m1_gnt_o) begin
            starve_d = '0;
        end else if (m1_req_i && (starve_q != SMAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // State, starvation count and outstanding-read tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            rd_valid_q <= rd_valid_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // Returning read data is steered only to the master that issued the read
    always_comb begin
        m0_rvalid_o = rd_valid_q && !rd_owner_q;
        m1_rvalid_o = rd_valid_q && rd_owner_q;
        m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
        m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    dmem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_wstrb_i(m0_wstrb), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_wstrb_i(m1_wstrb), .m1_lock_i(m1_lock), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid),
        .m1_rdata_o(m1_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_wstrb_o(mem_wstrb), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          g0;
        bit          g1;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          rv0;
        bit          rv1;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] rq0[$];
    logic [31:0] rq1[$];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] init_word(input int i);
        return (i == 0) ? 32'hDEADBEEF : (32'h1000_0000 + 32'(i) * 32'h0001_0203);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // Memory seen by the DUT: written/read through its mem_* port
    logic [31:0] bmem[64];
    bit          bw[64];
    always @(posedge clk) begin
        if (mem_en && !mem_we)
            mem_rdata <= bw[mem_addr[7:2]] ? bmem[mem_addr[7:2]] : init_word(int'(mem_addr[7:2]));
        if (mem_en && mem_we) begin
            bmem[mem_addr[7:2]] <= merge(bw[mem_addr[7:2]] ? bmem[mem_addr[7:2]]
                                         : init_word(int'(mem_addr[7:2])), mem_wdata, mem_wstrb);
            bw[mem_addr[7:2]]   <= 1'b1;
        end
    end

    // Reference model state
    logic [31:0] rmem[64];
    bit          rw[64];
    int          m_starve = 0;
    bit          m_locked = 0, m_prv0 = 0, m_prv1 = 0, m_g0 = 0, m_g1 = 0;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return rw[a[7:2]] ? rmem[a[7:2]] : init_word(int'(a[7:2]));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic [3:0] s0, input bit r1, input bit w1, input logic [31:0] a1,
                        input logic [31:0] d1, input logic [3:0] s1, input bit lk);
        exp_t e;
        bit   g0, g1;
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0; m0_wstrb = s0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_wstrb = s1; m1_lock = lk;
        g1 = r1 && (m_locked || (m_starve >= SM) || !r0);
        g0 = r0 && !g1 && !m_locked;
        e = '{g0: g0, g1: g1, we: 1'b0, addr: '0, wdata: '0, wstrb: '0, rv0: m_prv0, rv1: m_prv1};
        if (g0) begin
            e.we = w0; e.addr = a0; e.wdata = d0; e.wstrb = s0;
        end else if (g1) begin
            e.we = w1; e.addr = a1; e.wdata = d1; e.wstrb = s1;
        end
        if (g0 || g1) begin
            if (e.we) begin
                rmem[e.addr[7:2]] = merge(ref_rd(e.addr), e.wdata, e.wstrb);
                rw[e.addr[7:2]]   = 1'b1;
            end else if (g0) rq0.push_back(ref_rd(e.addr));
            else             rq1.push_back(ref_rd(e.addr));
        end
        m_prv0 = g0 && !w0;
        m_prv1 = g1 && !w1;
        if (g1) m_starve = 0;
        else if (r1 && m_starve < SM) m_starve++;
        if (g1) m_locked = lk;
        else    m_locked = 1'b0;
        m_g0 = g0; m_g1 = g1;
        expq.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        exp_t e;
        e = '{g0: 0, g1: 0, we: 0, addr: '0, wdata: '0, wstrb: '0, rv0: 0, rv1: 0};
        rst_n = 1'b0;
        m_locked = 0; m_starve = 0; m_prv0 = 0; m_prv1 = 0;
        rq0.delete(); rq1.delete();
        repeat (n) begin
            m0_req = 1'($urandom); m1_req = 1'($urandom); m1_lock = 1'($urandom);
            m0_we = 1'($urandom); m0_addr = $urandom;
            expq.push_back(e);
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
    endtask

    // Monitor: one expectation per cycle, read data popped when rvalid is due
    int wait1 = 0;
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] d;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("m0_gnt", m0_gnt, e.g0);
            chk("m1_gnt", m1_gnt, e.g1);
            chk("mem_en", mem_en, e.g0 | e.g1);
            chk("mem_we", mem_we, e.we);
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_wdata", mem_wdata, e.wdata);
            chk("mem_wstrb", mem_wstrb, e.wstrb);
            chk("m0_rvalid", m0_rvalid, e.rv0);
            chk("m1_rvalid", m1_rvalid, e.rv1);
            if (e.rv0) begin
                d = (rq0.size() > 0) ? rq0.pop_front() : 32'hx;
                chk("m0_rdata", m0_rdata, d);
            end else chk("m0_rdata_idle", m0_rdata, 0);
            if (e.rv1) begin
                d = (rq1.size() > 0) ? rq1.pop_front() : 32'hx;
                chk("m1_rdata", m1_rdata, d);
            end else chk("m1_rdata_idle", m1_rdata, 0);
        end
        if (!rst_n) wait1 = 0;
        else if (m1_req && !m1_gnt) wait1++;
        else begin
            if (m1_gnt) chk("m1_wait_bound", (wait1 <= SM), 1);
            wait1 = 0;
        end
    end

    initial begin
        int n1;
        bit r0, r1, w0, w1, lk;
        @(posedge clk); #1;
        do_reset(2);
        // Solo M0 read
        step(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Both request continuously: starvation rotation
        for (int i = 0; i < 12; i++)
            step(1, 0, 32'(i * 4), 0, 0, 1, 0, 32'(i * 4 + 64), 0, 0, 0);
        // M1 locked write burst while M0 keeps asking
        n1 = 0;
        for (int i = 0; i < 20 && n1 < 3; i++) begin
            step(1, 0, 32'h10, 0, 0, 1, 1, 32'h20, 32'h12345678, 4'hF, 1);
            if (m_g1) n1++;
        end
        chk("lock_beats", n1, 3);
        for (int i = 0; i < 3; i++) step(1, 0, 32'h20, 0, 0, 0, 0, 0, 0, 0, 0);
        // Lock without request is ignored
        step(1, 0, 32'h24, 0, 0, 0, 0, 0, 0, 0, 1);
        // Alternating reads M1 then M0
        step(0, 0, 0, 0, 0, 1, 0, 32'h200, 0, 0, 0);
        step(1, 0, 32'h204, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Reset right after an M0 read grant, then a normal read
        step(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset(2);
        step(1, 0, 32'h104, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            r0 = ($urandom_range(0, 3) != 0);
            r1 = ($urandom_range(0, 2) != 0);
            w0 = 1'($urandom);
            w1 = 1'($urandom);
            lk = ($urandom_range(0, 3) == 0);
            step(r0, w0, 32'($urandom_range(0, 15)) * 4, $urandom, 4'($urandom),
                 r1, w1, 32'($urandom_range(0, 15)) * 4, $urandom, 4'($urandom), lk);
            if (i == 1000) do_reset(1);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rq0_drained", rq0.size(), 0);
        chk("rq1_drained", rq1.size(), 0);
        chk("expq_drained", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
